// File: rtl/wb_retry_bus_if_if.sv
// rtl/wb_retry_bus_if_if.sv - Wishbone master-side signal bundle for wb_retry_bus_if
interface wb_retry_bus_if_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
) ();
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_retry_bus_if.sv
// rtl/wb_retry_bus_if.sv - CPU-to-Wishbone bridge with retry, timeout and pipeline stall handshake
module wb_retry_bus_if #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int SW        = DW / 8,
  parameter int STALLW    = 6,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALLW-1:0] stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [AW-1:0]     cpu_addr_i,
  input  logic [DW-1:0]     cpu_data_i,
  input  logic [SW-1:0]     cpu_sel_i,
  output logic [DW-1:0]     cpu_data_o,
  output logic              cpu_err_o,
  output logic              stallreq,
  wb_retry_bus_if_if.master wb
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    BACKOFF        = 2'd2,
    WAIT_FOR_STALL = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          stb_q, stb_d;
  logic [DW-1:0] rd_buf_q, rd_buf_d;
  logic          err_buf_q, err_buf_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          release_bus, complete, fail;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    stb_d       = stb_q;
    rd_buf_d    = rd_buf_q;
    err_buf_d   = err_buf_q;
    retry_cnt_d = retry_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    release_bus = 1'b0;
    complete    = 1'b0;
    fail        = 1'b0;
    stallreq    = 1'b0;
    cpu_data_o  = '0;
    cpu_err_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          adr_d       = cpu_addr_i;
          dat_d       = cpu_data_i;
          we_d        = cpu_we_i;
          sel_d       = cpu_sel_i;
          stb_d       = 1'b1;
          retry_cnt_d = '0;
          tmo_cnt_d   = '0;
          state_d     = BUSY;
          stallreq    = 1'b1;
        end
      end
      BUSY: begin
        // Fixed response priority: ack > err > rty > flush > timeout.
        if (wb.wb_ack_i) begin
          release_bus = 1'b1;
          complete    = 1'b1;
          rd_buf_d    = we_q ? '0 : wb.wb_dat_i;
          err_buf_d   = 1'b0;
          cpu_data_o  = we_q ? '0 : wb.wb_dat_i;
        end else if (wb.wb_err_i || (wb.wb_rty_i && retry_cnt_q == RW'(MAX_RETRY))) begin
          fail = 1'b1;
        end else if (wb.wb_rty_i) begin
          stb_d       = 1'b0;
          retry_cnt_d = retry_cnt_q + RW'(1);
          state_d     = BACKOFF;
          stallreq    = 1'b1;
        end else if (flush_i) begin
          release_bus = 1'b1;
          rd_buf_d    = '0;
          err_buf_d   = 1'b0;
          state_d     = IDLE;
        end else if (TIMEOUT != 0 && tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          if (TIMEOUT != 0) tmo_cnt_d = tmo_cnt_q + TW'(1);
          stallreq = 1'b1;
        end

        if (fail) begin
          release_bus = 1'b1;
          complete    = 1'b1;
          rd_buf_d    = '0;
          err_buf_d   = 1'b1;
          cpu_err_o   = 1'b1;
        end
        if (complete) state_d = (|stall_i) ? WAIT_FOR_STALL : IDLE;
      end
      BACKOFF: begin
        stb_d     = 1'b1;
        tmo_cnt_d = '0;
        state_d   = BUSY;
        stallreq  = 1'b1;
      end
      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf_q;
        cpu_err_o  = err_buf_q;
        if (stall_i == '0 || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (release_bus) begin
      stb_d = 1'b0;
      adr_d = '0;
      dat_d = '0;
      we_d  = 1'b0;
      sel_d = '0;
    end

    // Reset silences the CPU side immediately, not only after the edge.
    if (rst) begin
      stallreq   = 1'b0;
      cpu_data_o = '0;
      cpu_err_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      stb_q       <= 1'b0;
      rd_buf_q    <= '0;
      err_buf_q   <= 1'b0;
      retry_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      stb_q       <= stb_d;
      rd_buf_q    <= rd_buf_d;
      err_buf_q   <= err_buf_d;
      retry_cnt_q <= retry_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  // stb and cyc share one register so they can never disagree.
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_cyc_o = stb_q;
endmodule

// File: tb/tb_wb_retry_bus_if.sv
// tb/tb_wb_retry_bus_if.sv - self-checking bench for wb_retry_bus_if
module tb_wb_retry_bus_if;
  localparam int DW = 32, AW = 32, SW = 4, STALLW = 6, MAXR = 3, TMO = 8;
  localparam int K_ACK = 0, K_ERR = 1, K_TMO = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          n_rty;
    int          kind;
    int          d;
    logic [5:0]  stall;
    int          k;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_hi;
    int          exp_gaps;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [STALLW-1:0] stall_i;
  logic flush_i, ce, ce0, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] sel;
  logic [DW-1:0] s_dat;
  logic s_ack, s_err, s_rty;
  logic [DW-1:0] cpu_data, cpu_data0;
  logic cpu_err, cpu_err0, stallreq, stallreq0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_retry_bus_if_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();
  wb_retry_bus_if_if #(.AW(AW), .DW(DW), .SW(SW)) bus0 ();

  assign bus.wb_dat_i  = s_dat;
  assign bus.wb_ack_i  = s_ack;
  assign bus.wb_err_i  = s_err;
  assign bus.wb_rty_i  = s_rty;
  assign bus0.wb_dat_i = s_dat;
  assign bus0.wb_ack_i = s_ack;
  assign bus0.wb_err_i = s_err;
  assign bus0.wb_rty_i = s_rty;

  wb_retry_bus_if #(.DW(DW), .AW(AW), .SW(SW), .STALLW(STALLW), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_sel_i(sel),
    .cpu_data_o(cpu_data), .cpu_err_o(cpu_err), .stallreq(stallreq), .wb(bus.master)
  );

  wb_retry_bus_if #(.DW(DW), .AW(AW), .SW(SW), .STALLW(STALLW), .TIMEOUT(0), .MAX_RETRY(MAXR)) dut0 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(ce0), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_sel_i(sel),
    .cpu_data_o(cpu_data0), .cpu_err_o(cpu_err0), .stallreq(stallreq0), .wb(bus0.master)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level outcome: retries consume (d+1) BUSY cycles plus one backoff each.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int nr = (v.n_rty > MAXR) ? MAXR : v.n_rty;
    r.exp_gaps = nr;
    if (v.n_rty > MAXR) begin
      r.exp_err = 1'b1; r.exp_data = '0; r.exp_hi = 1 + nr * (v.d + 2) + v.d;
    end else if (v.kind == K_ACK) begin
      r.exp_err = 1'b0; r.exp_data = v.we ? 32'h0 : v.rdata; r.exp_hi = 1 + nr * (v.d + 2) + v.d;
    end else if (v.kind == K_ERR) begin
      r.exp_err = 1'b1; r.exp_data = '0; r.exp_hi = 1 + nr * (v.d + 2) + v.d;
    end else begin
      r.exp_err = 1'b1; r.exp_data = '0; r.exp_hi = 1 + nr * (v.d + 2) + (TMO - 1);
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    int a = 0, cnt = 0, hi = 0, gaps = 0;
    bit seen = 0, bus_bad = 0, done = 0, wfs_bad = 0;
    @(negedge clk);
    ce = 1'b1; we = v.we; addr = v.addr; wdata = v.data; sel = v.sel;
    stall_i = v.stall; flush_i = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = $urandom;
      if (bus.wb_stb_o && cnt == v.d) begin
        if (a < v.n_rty) begin
          s_rty = 1'b1; flush_i = 1'($urandom);
        end else if (v.kind == K_ACK) begin
          s_ack = 1'b1; s_dat = v.rdata;
          s_err = 1'($urandom); s_rty = 1'($urandom); flush_i = 1'($urandom);
        end else if (v.kind == K_ERR) begin
          s_err = 1'b1; s_rty = 1'($urandom); flush_i = 1'($urandom);
        end
      end
      #1;
      if (bus.wb_stb_o !== bus.wb_cyc_o) bus_bad = 1;
      if (bus.wb_stb_o) begin
        seen = 1;
        if (bus.wb_adr_o !== v.addr || bus.wb_dat_o !== v.data ||
            bus.wb_we_o !== v.we || bus.wb_sel_o !== v.sel) bus_bad = 1;
      end else if (seen && stallreq) gaps++;
      if (!stallreq) begin
        done = 1;
        chk("done_data", cpu_data, v.exp_data);
        chk("done_err", cpu_err, v.exp_err);
        break;
      end
      hi++;
      if (bus.wb_stb_o) begin
        if (a < v.n_rty && cnt == v.d) begin a++; cnt = 0; end
        else cnt++;
      end
      @(negedge clk);
      ce = 1'b0; flush_i = 1'b0;
      we = 1'($urandom); addr = $urandom; wdata = $urandom; sel = 4'($urandom);
    end
    if (!done) chk("completion_bound", 0, 1);
    chk("stallreq_cycles", hi, v.exp_hi);
    chk("retry_gaps", gaps, v.exp_gaps);
    chk("bus_hold", bus_bad, 0);
    @(negedge clk);
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; flush_i = 1'b0;
    if (v.k > 0) begin
      for (int i = 0; i <= v.k; i++) begin
        if (i == v.k) stall_i = '0;
        #1;
        if (stallreq !== 1'b0 || cpu_data !== v.exp_data || cpu_err !== v.exp_err) wfs_bad = 1;
        @(negedge clk);
      end
      chk("wfs_hold", wfs_bad, 0);
    end else stall_i = '0;
    #1;
    chk("post_idle", {stallreq, cpu_err, bus.wb_stb_o, bus.wb_adr_o, cpu_data}, '0);
  endtask

  vec_t tbl[7];
  vec_t rv;
  int bad;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        we    addr          data          sel      rdata         nr kind   d  stall      k  err   data          hi gaps
    tbl[0] = '{1'b0, 32'h100,      32'h0,        4'hF,    32'hDEADBEEF, 0, K_ACK, 1, 6'b000000, 0, 1'b0, 32'hDEADBEEF, 2, 0};
    tbl[1] = '{1'b1, 32'h104,      32'hCAFEF00D, 4'b0011, 32'h11111111, 0, K_ACK, 0, 6'b000100, 2, 1'b0, 32'h0,        1, 0};
    tbl[2] = '{1'b0, 32'h2000,     32'h0,        4'hF,    32'h12345678, 3, K_ACK, 0, 6'b000000, 0, 1'b0, 32'h12345678, 7, 3};
    tbl[3] = '{1'b0, 32'h3000,     32'h0,        4'hF,    32'h87654321, 4, K_ACK, 0, 6'b000000, 0, 1'b1, 32'h0,        7, 3};
    tbl[4] = '{1'b0, 32'h4000,     32'h0,        4'hF,    32'hAAAA5555, 0, K_TMO, 0, 6'b000000, 0, 1'b1, 32'h0,        8, 0};
    tbl[5] = '{1'b0, 32'h5000,     32'h0,        4'h1,    32'h0F0F0F0F, 0, K_ERR, 3, 6'b100000, 1, 1'b1, 32'h0,        4, 0};
    tbl[6] = '{1'b1, 32'h6000,     32'h13572468, 4'hC,    32'h0,        1, K_TMO, 0, 6'b000001, 1, 1'b1, 32'h0,        10, 1};

    rst = 1'b1; ce = 1'b1; ce0 = 1'b0; we = 1'b0; addr = 32'h100; wdata = '0; sel = '0;
    stall_i = '0; flush_i = 1'b0; s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    @(negedge clk); #1;
    chk("reset_outputs", {stallreq, cpu_err, cpu_data}, '0);
    chk("reset_bus", {bus.wb_stb_o, bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o}, '0);
    @(negedge clk);
    rst = 1'b0; ce = 1'b0;

    @(negedge clk);
    ce = 1'b1; flush_i = 1'b1; #1;
    chk("idle_flush_stallreq", stallreq, 0);
    @(negedge clk);
    ce = 1'b0; flush_i = 1'b0; #1;
    chk("idle_flush_no_start", bus.wb_stb_o, 0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    for (int i = 0; i < 60; i++) begin
      rv.we = 1'($urandom); rv.addr = $urandom; rv.data = $urandom; rv.sel = 4'($urandom);
      rv.rdata = $urandom; rv.n_rty = $urandom_range(0, 4); rv.kind = $urandom_range(0, 2);
      rv.d = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin rv.stall = 6'($urandom_range(1, 63)); rv.k = $urandom_range(1, 2); end
      else begin rv.stall = '0; rv.k = 0; end
      rv = model(rv);
      run_txn(rv);
    end

    // Flush while BUSY releases the bus with no data returned.
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h200; #1;
    @(negedge clk);
    ce = 1'b0; #1;
    chk("flush_busy_stb", bus.wb_stb_o, 1);
    @(negedge clk);
    flush_i = 1'b1; s_dat = 32'h55AA55AA; #1;
    chk("flush_cycle_out", {stallreq, cpu_err, cpu_data}, '0);
    @(negedge clk);
    flush_i = 1'b0; #1;
    chk("flush_released", {bus.wb_stb_o, stallreq, bus.wb_adr_o}, '0);

    // Reset landing in BACKOFF must not let the retry resume.
    @(negedge clk);
    ce = 1'b1; addr = 32'h300; #1;
    @(negedge clk);
    ce = 1'b0; s_rty = 1'b1; #1;
    chk("rty_stallreq", stallreq, 1);
    @(negedge clk);
    s_rty = 1'b0; #1;
    chk("backoff_state", {bus.wb_stb_o, stallreq}, 2'b01);
    rst = 1'b1; #1;
    chk("rst_silences", {stallreq, cpu_err, cpu_data}, '0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.wb_stb_o !== 1'b0 || stallreq !== 1'b0 || cpu_data !== '0) bad++;
      @(negedge clk);
    end
    chk("rst_no_retry", bad, 0);

    // With timeout disabled the request is held until something else ends it.
    ce0 = 1'b1; addr = 32'hA5A50000; #1;
    @(negedge clk);
    ce0 = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (bus0.wb_stb_o !== 1'b1 || stallreq0 !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("no_timeout_hold", bad, 0);
    flush_i = 1'b1; #1;
    chk("no_timeout_flush", stallreq0, 0);
    @(negedge clk);
    flush_i = 1'b0; #1;
    chk("no_timeout_released", bus0.wb_stb_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
